// File: rtl/tm_err_pkg.sv
// Shared types and default widths for the approximate-multiplier error monitor.
package tm_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PIPE_DEPTH = 3;

  localparam int DEF_N     = 8;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

endpackage

// File: rtl/tm_err_exact_mul.sv
// Stage S2: registered exact N x N unsigned multiply, carrying approx and valid alongside.
// With TM_ERR_MON_WCE_EN the operands are also carried forward for worst-case capture.
module tm_err_exact_mul
  import tm_err_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           valid,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2*N-1:0] approx,
`ifdef TM_ERR_MON_WCE_EN
  output logic [N-1:0]   a_q,
  output logic [N-1:0]   b_q,
`endif
  output logic           valid_q,
  output logic [2*N-1:0] exact,
  output logic [2*N-1:0] approx_q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q  <= 1'b0;
      exact    <= '0;
      approx_q <= '0;
`ifdef TM_ERR_MON_WCE_EN
      a_q      <= '0;
      b_q      <= '0;
`endif
    end else begin
      valid_q <= valid;
      if (valid) begin
        exact    <= (2*N)'(a) * (2*N)'(b);
        approx_q <= approx;
`ifdef TM_ERR_MON_WCE_EN
        a_q      <= a;
        b_q      <= b;
`endif
      end
    end
  end

endmodule

// File: rtl/tm8_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier: 3-stage pipeline, windowed run.
// Optional TM_ERR_MON_WCE_EN adds wce_a/wce_b capturing the operands of the worst-case sample.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, statistics zero after clear/rst
//   ST_RUN   | accepting samples until window reached
//   ST_DRAIN | window reached, last samples still in S1/S2
//   ST_DONE  | statistics final, done high
module tm8_err_monitor
  import tm_err_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] window,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [2*N-1:0]   approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [2*N-1:0]   err_max,
`ifdef TM_ERR_MON_WCE_EN
  output logic [N-1:0]     wce_a,
  output logic [N-1:0]     wce_b,
`endif
  output logic             sum_ovf
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] window_q;
  logic             accept;
  logic             start_ok;

  logic             s1_valid;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic [2*N-1:0]   s1_approx;

  logic             s2_valid;
  logic [2*N-1:0]   s2_exact;
  logic [2*N-1:0]   s2_approx;
`ifdef TM_ERR_MON_WCE_EN
  logic [N-1:0]     s2_a;
  logic [N-1:0]     s2_b;
`endif

  logic [2*N-1:0]   err;
  logic [ACC_W:0]   sum_nxt;

  assign in_ready = (state == ST_RUN) && (sample_cnt < window_q);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy     = (state == ST_RUN) || s1_valid || s2_valid;
  assign done     = (state == ST_DONE);

  // FSM
  always_ff @(posedge clk) begin
    if (rst || clear) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (window == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (accept && ((sample_cnt + CNT_W'(1)) == window_q)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // S2 is absorbed into the statistics on this edge, so an empty S1 means fully drained
        if (!s1_valid) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage S1
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_approx <= approx;
      end
    end
  end

  // Stage S2
  tm_err_exact_mul #(.N(N)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .valid    (s1_valid),
    .a        (s1_a),
    .b        (s1_b),
    .approx   (s1_approx),
`ifdef TM_ERR_MON_WCE_EN
    .a_q      (s2_a),
    .b_q      (s2_b),
`endif
    .valid_q  (s2_valid),
    .exact    (s2_exact),
    .approx_q (s2_approx)
  );

  // Stage S3
  assign err     = (s2_exact >= s2_approx) ? (s2_exact - s2_approx) : (s2_approx - s2_exact);
  assign sum_nxt = {1'b0, err_sum} + (ACC_W+1)'(err);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      window_q   <= '0;
      sample_cnt <= '0;
      mism_cnt   <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      sum_ovf    <= 1'b0;
`ifdef TM_ERR_MON_WCE_EN
      wce_a      <= '0;
      wce_b      <= '0;
`endif
    end else if (start_ok) begin
      window_q   <= window;
      sample_cnt <= '0;
      mism_cnt   <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      sum_ovf    <= 1'b0;
`ifdef TM_ERR_MON_WCE_EN
      wce_a      <= '0;
      wce_b      <= '0;
`endif
    end else begin
      if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
      if (s2_valid) begin
        if (err != '0) mism_cnt <= mism_cnt + CNT_W'(1);
        if (err > err_max) begin
          err_max <= err;
`ifdef TM_ERR_MON_WCE_EN
          wce_a   <= s2_a;
          wce_b   <= s2_b;
`endif
        end
        if (sum_nxt[ACC_W]) begin
          err_sum <= '1;
          sum_ovf <= 1'b1;
        end else begin
          err_sum <= sum_nxt[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_tm8_err_monitor.sv
// Directed bench for tm8_err_monitor; a second instance with a 16-bit accumulator covers saturation.
// Build with TM_ERR_MON_WCE_EN defined to also exercise the worst-case operand capture.
module tb_tm8_err_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clear, in_valid;
  logic [31:0] window;
  logic [7:0]  a, b;
  logic [15:0] approx;

  logic        in_ready, busy, done, sum_ovf;
  logic [31:0] sample_cnt, mism_cnt;
  logic [47:0] err_sum;
  logic [15:0] err_max;

  logic        rdy16, busy16, done16, ovf16;
  logic [31:0] sc16, mc16;
  logic [15:0] sum16, max16;
`ifdef TM_ERR_MON_WCE_EN
  logic [7:0]  wce_a, wce_b, wce_a16, wce_b16;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tm8_err_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .window(window),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .mism_cnt(mism_cnt),
    .err_sum(err_sum), .err_max(err_max),
`ifdef TM_ERR_MON_WCE_EN
    .wce_a(wce_a), .wce_b(wce_b),
`endif
    .sum_ovf(sum_ovf)
  );

  tm8_err_monitor #(.ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .window(window),
    .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b), .approx(approx),
    .busy(busy16), .done(done16), .sample_cnt(sc16), .mism_cnt(mc16),
    .err_sum(sum16), .err_max(max16),
`ifdef TM_ERR_MON_WCE_EN
    .wce_a(wce_a16), .wce_b(wce_b16),
`endif
    .sum_ovf(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] w);
    start  = 1'b1;
    window = w;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    window = 32'd0; a = 8'd0; b = 8'd0; approx = 16'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b exp 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", done); end
    checks++; if ({sample_cnt, mism_cnt, err_sum, err_max, sum_ovf} !== '0) begin
      errors++; $display("FAIL reset_stats: got sc=%0d mc=%0d sum=%0d max=%0d ovf=%0b exp all 0",
                         sample_cnt, mism_cnt, err_sum, err_max, sum_ovf); end
  endtask

  // approx drops everything but the a[7]&b[7] partial product
  task automatic test_trunc();
    do_start(32'd2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL trunc_ready: got %0b exp 1", in_ready); end
    in_valid = 1'b1; a = 8'd255; b = 8'd255; approx = 16'd16384;
    tick();
    checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL trunc_cnt1: got %0d exp 1", sample_cnt); end
    a = 8'd3; b = 8'd5; approx = 16'd0;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trunc_ready_after: got %0b exp 0", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL trunc_done_t1: got %0b exp 0", done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL trunc_done_t2: got done=%0b busy=%0b exp 0/1", done, busy); end
    checks++; if (err_max !== 16'd48641) begin errors++; $display("FAIL trunc_max_t2: got %0d exp 48641", err_max); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL trunc_done_t3: got done=%0b busy=%0b exp 1/0", done, busy); end
    checks++; if (err_sum !== 48'd48656) begin errors++; $display("FAIL trunc_sum: got %0d exp 48656", err_sum); end
    checks++; if (err_max !== 16'd48641) begin errors++; $display("FAIL trunc_max: got %0d exp 48641", err_max); end
    checks++; if (mism_cnt !== 32'd2 || sample_cnt !== 32'd2) begin errors++; $display("FAIL trunc_counts: got mc=%0d sc=%0d exp 2/2", mism_cnt, sample_cnt); end
`ifdef TM_ERR_MON_WCE_EN
    checks++; if (wce_a !== 8'd255 || wce_b !== 8'd255) begin errors++; $display("FAIL trunc_wce: got %0d,%0d exp 255,255", wce_a, wce_b); end
`endif
  endtask

  task automatic test_exact_random();
    int hs = 0;
    do_start(32'd256);
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      approx = 16'(a) * 16'(b);
      if (in_ready === 1'b1) hs++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (hs != 256) begin errors++; $display("FAIL exact_handshakes: got %0d exp 256", hs); end
    for (int i = 0; i < 10 && done !== 1'b1; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL exact_done: got %0b exp 1", done); end
    checks++; if (mism_cnt !== 32'd0 || err_sum !== 48'd0 || err_max !== 16'd0) begin
      errors++; $display("FAIL exact_stats: got mc=%0d sum=%0d max=%0d exp 0", mism_cnt, err_sum, err_max); end
    checks++; if (sample_cnt !== 32'd256) begin errors++; $display("FAIL exact_cnt: got %0d exp 256", sample_cnt); end
  endtask

  task automatic test_window_zero();
    int rdy_seen = 0;
    in_valid = 1'b1; a = 8'd9; b = 8'd9; approx = 16'd0;
    do_start(32'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wz_done: got %0b exp 1", done); end
    checks++; if ({sample_cnt, mism_cnt, err_sum, err_max, sum_ovf} !== '0) begin
      errors++; $display("FAIL wz_stats: got sc=%0d mc=%0d sum=%0d max=%0d exp 0", sample_cnt, mism_cnt, err_sum, err_max); end
    for (int i = 0; i < 4; i++) begin
      if (in_ready === 1'b1) rdy_seen++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (rdy_seen != 0 || sample_cnt !== 32'd0) begin errors++; $display("FAIL wz_ready: got rdy=%0d sc=%0d exp 0/0", rdy_seen, sample_cnt); end
  endtask

  task automatic test_clear();
    do_start(32'd10);
    in_valid = 1'b1; a = 8'd1; b = 8'd1; approx = 16'd0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (sample_cnt !== 32'd5 || mism_cnt !== 32'd3) begin
      errors++; $display("FAIL clear_pre: got sc=%0d mc=%0d exp 5/3", sample_cnt, mism_cnt); end
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if ({in_ready, busy, done, sample_cnt, mism_cnt, err_sum, err_max, sum_ovf} !== '0) begin
      errors++; $display("FAIL clear_outputs: got rdy=%0b busy=%0b done=%0b sc=%0d mc=%0d sum=%0d max=%0d exp all 0",
                         in_ready, busy, done, sample_cnt, mism_cnt, err_sum, err_max); end
    tick(); tick(); tick();
    checks++; if (mism_cnt !== 32'd0 || err_sum !== 48'd0) begin
      errors++; $display("FAIL clear_inflight: got mc=%0d sum=%0d exp 0/0", mism_cnt, err_sum); end
    start = 1'b1; clear = 1'b1; window = 32'd3;
    tick();
    start = 1'b0; clear = 1'b0;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL clear_wins: got rdy=%0b busy=%0b done=%0b exp 0/0/0", in_ready, busy, done); end
  endtask

  task automatic test_hold_valid();
    int hs = 0;
    do_start(32'd4);
    in_valid = 1'b1; a = 8'd2; b = 8'd3; approx = 16'd5;
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b1) hs++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (hs != 4 || sample_cnt !== 32'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_handshakes: got hs=%0d sc=%0d rdy=%0b exp 4/4/0", hs, sample_cnt, in_ready); end
    checks++; if (done !== 1'b1 || mism_cnt !== 32'd4 || err_sum !== 48'd4 || err_max !== 16'd1) begin
      errors++; $display("FAIL hold_stats: got done=%0b mc=%0d sum=%0d max=%0d exp 1/4/4/1", done, mism_cnt, err_sum, err_max); end
    do_start(32'd4);
    checks++; if ({sample_cnt, mism_cnt, err_sum, err_max} !== '0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL restart: got sc=%0d mc=%0d sum=%0d max=%0d done=%0b rdy=%0b exp 0/0/0/0/0/1",
                         sample_cnt, mism_cnt, err_sum, err_max, done, in_ready); end
    do_start(32'd1);
    hs = 0;
    in_valid = 1'b1; a = 8'd4; b = 8'd4; approx = 16'd16;
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b1) hs++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (hs != 4 || sample_cnt !== 32'd4 || done !== 1'b1) begin
      errors++; $display("FAIL start_in_run: got hs=%0d sc=%0d done=%0b exp 4/4/1", hs, sample_cnt, done); end
  endtask

  task automatic test_saturation();
    do_start(32'd3);
    in_valid = 1'b1; a = 8'd255; b = 8'd255; approx = 16'd16384;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && done16 !== 1'b1; i++) tick();
    checks++; if (done16 !== 1'b1 || sum16 !== 16'd65535 || ovf16 !== 1'b1) begin
      errors++; $display("FAIL sat16: got done=%0b sum=%0d ovf=%0b exp 1/65535/1", done16, sum16, ovf16); end
    checks++; if (err_sum !== 48'd145923 || sum_ovf !== 1'b0) begin
      errors++; $display("FAIL sat48: got sum=%0d ovf=%0b exp 145923/0", err_sum, sum_ovf); end
    tick(); tick(); tick();
    checks++; if (ovf16 !== 1'b1 || sum16 !== 16'd65535) begin
      errors++; $display("FAIL sat_sticky: got ovf=%0b sum=%0d exp 1/65535", ovf16, sum16); end
    do_start(32'd0);
    checks++; if (ovf16 !== 1'b0 || sum16 !== 16'd0) begin
      errors++; $display("FAIL sat_cleared: got ovf=%0b sum=%0d exp 0/0", ovf16, sum16); end
  endtask

  initial begin
    test_reset();
    test_trunc();
    test_exact_random();
    test_window_zero();
    test_clear();
    test_hold_valid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm8_err_monitor.md
# tm8_err_monitor

Sequential error-statistics monitor that sits directly downstream of an 8×8 unsigned truncated/approximate multiplier. It accepts each operand pair together with the approximate product, recomputes the exact product internally, and accumulates error metrics over a programmed window of samples. The metrics are the number of mismatches, the sum of absolute error and the maximum absolute error. It is used in characterisation benches and on-chip self-test of approximate multiplier variants.

## Interface
- `N`, 8: operand width; products are 2N bits.
- `CNT_W`, 32: width of the window and counter registers.
- `ACC_W`, 48: width of the error-sum accumulator.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse; latches `window`, clears the statistics and enters RUN.
- `clear` input 1: synchronous abort; flushes the pipeline and returns to IDLE with statistics zeroed.
- `window` input CNT_W: number of samples to accept per run.
- `in_valid` input 1: sample present.
- `in_ready` output 1: monitor accepts the sample this cycle.
- `a`, `b` input N: operands.
- `approx` input 2N: approximate product under test.
- `busy` output 1: state is RUN, or the pipeline is not yet drained.
- `done` output 1: level, high in DONE.
- `sample_cnt` output CNT_W: accepted samples.
- `mism_cnt` output CNT_W: samples with nonzero error.
- `err_sum` output ACC_W: Σ|exact − approx|, saturating.
- `err_max` output 2N: maximum |exact − approx|.
- `sum_ovf` output 1: sticky flag; `err_sum` has saturated.

## Operation
- FSM states:
  - IDLE → RUN on `start`. If `window` = 0, the transition is IDLE → DONE instead, taken the next cycle.
  - RUN → DRAIN when the accepted count reaches `window`.
  - DRAIN → DONE when the pipeline is empty.
  - DONE → RUN on `start`, with statistics cleared.
- `clear` forces IDLE from any state. `rst` has the same effect.
- `in_ready` = (state == RUN) && (accepted < window). The handshake is `in_valid && in_ready`. There is no backpressure inside the pipeline.
- Pipeline stages:
  - S1: register a, b, approx and a valid bit.
  - S2: exact = a·b (2N bits); register exact, approx and valid.
  - S3: err = |exact − approx| as an unsigned 2N-bit value; update the statistics if valid.
- `mism_cnt` increments when err ≠ 0.
- `err_max` = max(err_max, err).
- `err_sum` adds err, zero-extended to ACC_W. On carry-out it clamps to all-ones and sets `sum_ovf`.
- `start` while in RUN or DRAIN is ignored.

## Timing
- Reset and `clear` values: all outputs 0, state IDLE, pipeline valid bits 0.
- Latency: a sample accepted at cycle t is reflected in the statistics at t+3.
- `sample_cnt` updates at acceptance (t+1). The other statistics update at t+3.
- `done` rises 3 cycles after the last acceptance. With `window` = 0, `done` rises 1 cycle after `start`.
- `in_ready` is low in the cycle after the last acceptance. Back-to-back acceptance is possible every cycle.
- If `start` and `clear` are asserted together, `clear` wins.

## Configuration
- `TM_ERR_MON_WCE_EN`:
  - Defined: adds outputs `wce_a` and `wce_b` (N bits each, reset 0). They capture the operands of the first sample that strictly increases `err_max`, updated in S3. S1/S2 carry the operands forward for this purpose.
  - Undefined: these ports and registers are absent, and the operands are not carried beyond S2.

## Structure
- Package `tm_err_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Pipeline depth constant (3).
  - Default widths.
- Sub-module `tm_err_exact_mul`: registered N×N unsigned exact multiplier used as stage S2, kept separate so it can be swapped for a generated array multiplier.

## Test plan
- approx = (a[7]&b[7])<<14, window = 2, samples (255,255) and (3,5):
  - err values 48641 and 15.
  - err_sum = 48656, err_max = 48641, mism_cnt = 2.
  - `done` 3 cycles after the 2nd acceptance.
- approx = exact a·b for 256 random samples: mism_cnt = 0, err_sum = 0, err_max = 0, sample_cnt = 256.
- window = 0, `start` → `done` the next cycle, all statistics 0, `in_ready` never high.
- `clear` asserted mid-run after 5 of 10 samples: next cycle IDLE, all outputs 0. Samples still in flight are not counted.
- `in_valid` held high with window = 4: exactly 4 handshakes, then `in_ready` low. A new `start` in DONE restarts with zeroed statistics.
- ACC_W forced to 16, repeated err = 48641: `err_sum` saturates at 65535 and `sum_ovf` = 1 stays set until `start`, `clear` or `rst`.
